// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory write bus for instr_encoder_loader.
// slave: the encoder side; master: the requester / memory side.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        mn;
  logic [3:0]        cond;
  logic              s;
  logic              imm_sel;
  logic [3:0]        rd;
  logic [3:0]        rn;
  logic [3:0]        rm;
  logic [11:0]       imm;
  logic [ADDR_W-1:0] target;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;

  modport slave (
    input  req_valid, mn, cond, s, imm_sel, rd, rn, rm, imm, target, mem_ready,
    output req_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, mn, cond, s, imm_sel, rd, rn, rm, imm, target, mem_ready,
    input  req_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Sequential ARM-subset instruction encoder that writes each encoded word
// to instruction memory at consecutive word addresses.
// Optional macro ENC_RANGE_CHECK_EN: reject DP immediates with imm[11:8] != 0
// and branch offsets that do not fit 26-bit signed (otherwise truncated).
module instr_encoder_loader #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DEPTH     = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  instr_encoder_loader_if.slave      bus,
  output logic                       err,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = (ADDR_W > 26) ? ADDR_W : 26;

  typedef enum logic [1:0] {IDLE, ENC, WRITE} state_t;

  state_t            state, state_nx;
  logic [3:0]        q_mn, q_cond, q_rd, q_rn, q_rm;
  logic              q_s, q_imm_sel;
  logic [11:0]       q_imm;
  logic [ADDR_W-1:0] q_target;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       word;
  logic [CW-1:0]     cnt;
  logic              err_q;
  logic              accept;
  logic              legal;
  logic [31:0]       enc_word;
  logic [3:0]        cmd;
  logic [ADDR_W-1:0] offset;
  logic [OW-1:0]     off_ext;
  logic              off_fits;

  assign full          = (cnt == CW'(DEPTH));
  assign count         = cnt;
  assign err           = err_q;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = word;
  assign accept        = (state == IDLE) && bus.req_valid && !full;

  // Branch offset relative to PC+8, sign-extended so bits [25:2] always exist.
  assign offset   = q_target - (addr + ADDR_W'(8));
  assign off_ext  = OW'($signed(offset));
  assign off_fits = (&off_ext[OW-1:25]) | ~(|off_ext[OW-1:25]);

`ifndef ENC_RANGE_CHECK_EN
  logic unused_off_fits;
  assign unused_off_fits = off_fits;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx      = state;
    bus.req_ready = 1'b0;
    bus.mem_we    = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = !full;
        if (accept) state_nx = ENC;
      end
      ENC:     state_nx = legal ? WRITE : IDLE;
      WRITE: begin
        bus.mem_we = 1'b1;
        if (bus.mem_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Encode the captured request and decide legality.
  always_comb begin
    cmd      = 4'b0000;
    legal    = 1'b1;
    enc_word = '0;
    unique case (q_mn)
      4'd0:    cmd = 4'b0100;
      4'd1:    cmd = 4'b0010;
      4'd2:    cmd = 4'b0000;
      4'd3:    cmd = 4'b1100;
      4'd4:    cmd = 4'b0001;
      4'd5:    cmd = 4'b1010;
      default: cmd = 4'b0000;
    endcase
    if (q_mn <= 4'd5) begin
      enc_word = {q_cond, 2'b00, q_imm_sel, cmd, q_s | (q_mn == 4'd5), q_rn,
                  (q_mn == 4'd5) ? 4'b0000 : q_rd,
                  q_imm_sel ? {4'h0, q_imm[7:0]} : {8'h00, q_rm}};
`ifdef ENC_RANGE_CHECK_EN
      if (q_imm_sel && (q_imm[11:8] != 4'h0)) legal = 1'b0;
`endif
    end else if ((q_mn == 4'd6) || (q_mn == 4'd7)) begin
      enc_word = {q_cond, 2'b01, 5'b01100, q_mn == 4'd6, q_rn, q_rd, q_imm};
    end else if (q_mn == 4'd8) begin
      enc_word = {q_cond, 4'b1010, off_ext[25:2]};
      // addr is always word aligned, so offset[1:0] equals target[1:0].
      if (off_ext[1:0] != 2'b00) legal = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
      if (!off_fits) legal = 1'b0;
`endif
    end else begin
      legal = 1'b0;
    end
  end

  // Request capture, word register, address/count advance and err pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_mn      <= '0;
      q_cond    <= '0;
      q_rd      <= '0;
      q_rn      <= '0;
      q_rm      <= '0;
      q_s       <= 1'b0;
      q_imm_sel <= 1'b0;
      q_imm     <= '0;
      q_target  <= '0;
      addr      <= BASE_ADDR;
      word      <= '0;
      cnt       <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (accept) begin
        q_mn      <= bus.mn;
        q_cond    <= bus.cond;
        q_rd      <= bus.rd;
        q_rn      <= bus.rn;
        q_rm      <= bus.rm;
        q_s       <= bus.s;
        q_imm_sel <= bus.imm_sel;
        q_imm     <= bus.imm;
        q_target  <= bus.target;
      end
      if (state == ENC) begin
        if (legal) word  <= enc_word;
        else       err_q <= 1'b1;
      end
      if ((state == WRITE) && bus.mem_ready) begin
        addr <= addr + ADDR_W'(4);
        cnt  <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader (DEPTH=4): directed steps
// followed by random requests checked against a field-level reference model.
module tb_instr_encoder_loader;
  localparam int DEPTH = 4;
`ifdef ENC_RANGE_CHECK_EN
  localparam bit RANGE = 1'b1;
`else
  localparam bit RANGE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       err, full;
  logic [2:0] count;
  int         errors = 0;
  int         checks = 0;
  logic [31:0] m_addr;
  int          m_cnt;

  instr_encoder_loader_if #(.ADDR_W(32)) bus ();

  instr_encoder_loader #(.ADDR_W(32), .BASE_ADDR(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .err(err), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: builds the word from the field rules with shifts/sums.
  function automatic logic [32:0] model(input int mnv, input int cv, input int sv, input int isel,
                                        input int rdv, input int rnv, input int rmv, input int immv,
                                        input logic [31:0] tgt, input logic [31:0] at);
    int cmd_tab [6];
    logic [31:0] w;
    bit ok;
    int off;
    cmd_tab = '{4, 2, 0, 12, 1, 10};
    ok = 1'b1;
    w = 32'(cv) << 28;
    if (mnv <= 5) begin
      w = w | (32'(isel) << 25) | (32'(cmd_tab[mnv]) << 21)
            | (32'((mnv == 5) ? 1 : sv) << 20) | (32'(rnv) << 16)
            | (32'((mnv == 5) ? 0 : rdv) << 12) | 32'(isel ? (immv % 256) : rmv);
      if (RANGE && isel && immv >= 256) ok = 1'b0;
    end else if (mnv == 6 || mnv == 7) begin
      w = w | (32'h1 << 26) | (32'((mnv == 6) ? 8'h19 : 8'h18) << 20)
            | (32'(rnv) << 16) | (32'(rdv) << 12) | 32'(immv);
    end else if (mnv == 8) begin
      off = int'(tgt - (at + 32'd8));
      w = w | (32'hA << 24) | (32'(off >>> 2) & 32'h00FF_FFFF);
      if (tgt % 4 != 0) ok = 1'b0;
      if (RANGE && (off < -(1 << 25) || off >= (1 << 25))) ok = 1'b0;
    end else begin
      ok = 1'b0;
    end
    return {ok, w};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_addr = 32'h0;
    m_cnt = 0;
    chk("rst_count", count, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_err", err, 0);
    chk("rst_full", full, 0);
    chk("rst_ready", bus.req_ready, 1);
  endtask

  // Issue one request and follow it through ENC and WRITE (or the err pulse).
  task automatic do_req(input string tag, input int mnv, input int cv, input int sv, input int isel,
                        input int rdv, input int rnv, input int rmv, input int immv,
                        input logic [31:0] tgt, input bit exp_ok, input logic [31:0] exp_w,
                        input int stall);
    int n = 0;
    bus.mn = 4'(mnv); bus.cond = 4'(cv); bus.s = 1'(sv); bus.imm_sel = 1'(isel);
    bus.rd = 4'(rdv); bus.rn = 4'(rnv); bus.rm = 4'(rmv); bus.imm = 12'(immv); bus.target = tgt;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      chk({tag, "_ready_timeout"}, 0, 1);
      return;
    end
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk({tag, "_enc_we"}, bus.mem_we, 0);
    chk({tag, "_enc_ready"}, bus.req_ready, 0);
    bus.mem_ready = (stall == 0);
    @(posedge clk); #1;
    if (exp_ok) begin
      for (int i = 0; i < stall; i++) begin
        chk({tag, "_stall_we"}, bus.mem_we, 1);
        chk({tag, "_stall_addr"}, bus.mem_addr, m_addr);
        chk({tag, "_stall_word"}, bus.mem_wdata, exp_w);
        chk({tag, "_stall_ready"}, bus.req_ready, 0);
        @(posedge clk); #1;
      end
      bus.mem_ready = 1'b1;
      chk({tag, "_we"}, bus.mem_we, 1);
      chk({tag, "_addr"}, bus.mem_addr, m_addr);
      chk({tag, "_word"}, bus.mem_wdata, exp_w);
      @(posedge clk); #1;
      m_addr = m_addr + 32'd4;
      m_cnt++;
      chk({tag, "_done_we"}, bus.mem_we, 0);
      chk({tag, "_count"}, count, m_cnt);
      chk({tag, "_next_addr"}, bus.mem_addr, m_addr);
      chk({tag, "_ready_again"}, bus.req_ready, (m_cnt != DEPTH));
    end else begin
      bus.mem_ready = 1'b1;
      chk({tag, "_err_hi"}, err, 1);
      chk({tag, "_err_we"}, bus.mem_we, 0);
      @(posedge clk); #1;
      chk({tag, "_err_lo"}, err, 0);
      chk({tag, "_err_we2"}, bus.mem_we, 0);
      chk({tag, "_err_count"}, count, m_cnt);
      chk({tag, "_err_addr"}, bus.mem_addr, m_addr);
      chk({tag, "_err_ready"}, bus.req_ready, 1);
    end
  endtask

  initial begin
    logic [32:0] r;
    logic [31:0] tgt;
    int mnv, cv, sv, isel, rdv, rnv, rmv, immv;
    bus.req_valid = 1'b0; bus.mem_ready = 1'b1;
    bus.mn = '0; bus.cond = '0; bus.s = 1'b0; bus.imm_sel = 1'b0;
    bus.rd = '0; bus.rn = '0; bus.rm = '0; bus.imm = '0; bus.target = '0;

    do_reset();
    do_req("add", 0, 14, 0, 1, 1, 2, 0, 5, 32'h0, 1'b1, 32'hE282_1005, 0);
    do_req("sub", 1, 14, 1, 0, 3, 4, 5, 0, 32'h0, 1'b1, 32'hE054_3005, 5);
    do_req("ill_mn", 15, 14, 0, 0, 0, 0, 0, 0, 32'h0, 1'b0, 32'h0, 0);
    do_req("ill_b", 8, 14, 0, 0, 0, 0, 0, 0, 32'h6, 1'b0, 32'h0, 0);
    do_req("cmp", 5, 14, 0, 1, 7, 0, 0, 0, 32'h0, 1'b1, 32'hE350_0000, 0);
    do_req("ldr", 6, 14, 0, 0, 2, 0, 0, 8, 32'h0, 1'b1, 32'hE590_2008, 1);

    chk("full_flag", full, 1);
    chk("full_ready", bus.req_ready, 0);
    chk("full_addr", bus.mem_addr, 32'h10);
    bus.mn = 4'd0; bus.req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("held_ready", bus.req_ready, 0);
      chk("held_we", bus.mem_we, 0);
      chk("held_err", err, 0);
      chk("held_count", count, 4);
      chk("held_addr", bus.mem_addr, 32'h10);
    end
    bus.req_valid = 1'b0;
    do_reset();

    do_req("add0", 0, 14, 0, 1, 1, 2, 0, 5, 32'h0, 1'b1, 32'hE282_1005, 0);
    do_req("b_back", 8, 14, 0, 0, 0, 0, 0, 0, 32'h0, 1'b1, 32'hEAFF_FFFD, 0);
`ifdef ENC_RANGE_CHECK_EN
    do_req("imm_wide", 0, 14, 0, 1, 1, 2, 0, 12'h1FF, 32'h0, 1'b0, 32'h0, 0);
`else
    do_req("imm_wide", 0, 14, 0, 1, 1, 2, 0, 12'h1FF, 32'h0, 1'b1, 32'hE282_10FF, 0);
`endif

    // Reset while a write is stalled drops the word.
    bus.mn = 4'd0; bus.imm_sel = 1'b1; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    chk("midrst_we_before", bus.mem_we, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bus.mem_ready = 1'b1;
    m_addr = 32'h0; m_cnt = 0;
    chk("midrst_we", bus.mem_we, 0);
    chk("midrst_count", count, 0);
    chk("midrst_addr", bus.mem_addr, 0);
    chk("midrst_ready", bus.req_ready, 1);

    for (int i = 0; i < 40; i++) begin
      if (m_cnt == DEPTH) do_reset();
      mnv  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 8));
      cv   = $urandom_range(0, 15);
      sv   = $urandom_range(0, 1);
      isel = $urandom_range(0, 1);
      rdv  = $urandom_range(0, 15);
      rnv  = $urandom_range(0, 15);
      rmv  = $urandom_range(0, 15);
      immv = $urandom_range(0, 4095);
      case ($urandom_range(0, 3))
        0:       tgt = $urandom;
        1:       tgt = m_addr + 32'($urandom_range(0, 3));
        default: tgt = m_addr - 32'd64 + 32'(4 * $urandom_range(0, 40));
      endcase
      r = model(mnv, cv, sv, isel, rdv, rnv, rmv, immv, tgt, m_addr);
      do_req($sformatf("rnd%0d", i), mnv, cv, sv, isel, rdv, rnv, rmv, immv, tgt,
             r[32], r[31:0], int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
